// File: rtl/dcache_profiler.sv
// Direct-mapped data-cache behaviour model that profiles an access stream:
// tracks valid/dirty/tag per line and counts hits, misses, write-backs and drops.
module dcache_profiler #(
    parameter int NUM_LINES  = 8,
    parameter int LINE_BYTES = 16
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        valid_i,
    input  logic        we_i,
    input  logic [31:0] addr_i,
    input  logic        flush_i,
    output logic        ready_o,
    output logic        hit_o,
    output logic        miss_o,
    output logic        wb_o,
    output logic [31:0] access_cnt_o,
    output logic [31:0] hit_cnt_o,
    output logic [31:0] miss_cnt_o,
    output logic [31:0] wb_cnt_o,
    output logic [31:0] drop_cnt_o,
    output logic [1:0]  dbg_state_o
);

    localparam int OFF  = $clog2(LINE_BYTES);
    localparam int IDX  = $clog2(NUM_LINES);
    localparam int TAGW = 32 - OFF - IDX;
    localparam logic [IDX-1:0] LAST_IDX = IDX'(NUM_LINES - 1);

    typedef enum logic [1:0] {
        INIT  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [IDX-1:0]      walk_q, walk_d;
    logic [NUM_LINES-1:0] valid_q, dirty_q;
    logic [TAGW-1:0]     tag_q [NUM_LINES];

    logic [IDX-1:0]  idx;
    logic [TAGW-1:0] tag;
    logic            unused_offset;
    logic            accept, drop, walking, line_hit, acc_wb, flush_wb;
    logic [1:0]      wb_inc;

    assign idx           = addr_i[OFF+IDX-1:OFF];
    assign tag           = addr_i[31:OFF+IDX];
    assign unused_offset = ^addr_i[OFF-1:0];

    // Handshake: an access is taken on a rising edge where valid_i && ready_o;
    // valid_i while ready_o is low is not stalled or retried, only counted as a drop.
    assign ready_o  = (state_q == RUN);
    assign accept   = valid_i & ready_o;
    assign drop     = valid_i & ~ready_o;
    assign walking  = (state_q != RUN);
    assign line_hit = valid_q[idx] && (tag_q[idx] == tag);
    assign acc_wb   = accept & ~line_hit & valid_q[idx] & dirty_q[idx];
    assign flush_wb = (state_q == FLUSH) & valid_q[walk_q] & dirty_q[walk_q];
    assign wb_inc   = {1'b0, acc_wb} + {1'b0, flush_wb};

    assign dbg_state_o = state_q;

    function automatic logic [31:0] sat_add(input logic [31:0] cnt, input logic [1:0] inc);
        logic [32:0] sum;
        sum = {1'b0, cnt} + {31'b0, inc};
        return sum[32] ? 32'hFFFF_FFFF : sum[31:0];
    endfunction

    always_comb begin
        state_d = state_q;
        walk_d  = walk_q;
        case (state_q)
            INIT, FLUSH: begin
                walk_d = walk_q + 1'b1;
                if (walk_q == LAST_IDX) begin
                    state_d = RUN;
                    walk_d  = '0;
                end
            end
            RUN: begin
                if (flush_i) state_d = FLUSH;
            end
            default: begin
                state_d = INIT;
                walk_d  = '0;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state_q <= INIT;
            walk_q  <= '0;
        end else begin
            state_q <= state_d;
            walk_q  <= walk_d;
        end
    end

    // INIT and FLUSH share the line walker; both leave the visited line invalid and clean.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            if (walking) begin
                valid_q[walk_q] <= 1'b0;
                dirty_q[walk_q] <= 1'b0;
                tag_q[walk_q]   <= '0;
            end else if (accept) begin
                if (line_hit) begin
                    if (we_i) dirty_q[idx] <= 1'b1;
                end else begin
                    tag_q[idx]   <= tag;
                    valid_q[idx] <= 1'b1;
                    dirty_q[idx] <= we_i;
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            hit_o        <= 1'b0;
            miss_o       <= 1'b0;
            wb_o         <= 1'b0;
            access_cnt_o <= '0;
            hit_cnt_o    <= '0;
            miss_cnt_o   <= '0;
            wb_cnt_o     <= '0;
            drop_cnt_o   <= '0;
        end else begin
            hit_o        <= accept & line_hit;
            miss_o       <= accept & ~line_hit;
            wb_o         <= acc_wb | flush_wb;
            access_cnt_o <= sat_add(access_cnt_o, {1'b0, accept});
            hit_cnt_o    <= sat_add(hit_cnt_o, {1'b0, accept & line_hit});
            miss_cnt_o   <= sat_add(miss_cnt_o, {1'b0, accept & ~line_hit});
            wb_cnt_o     <= sat_add(wb_cnt_o, wb_inc);
            drop_cnt_o   <= sat_add(drop_cnt_o, {1'b0, drop});
        end
    end

endmodule

// File: tb/tb_dcache_profiler.sv
// Directed bench for dcache_profiler: expected result pulses are queued at issue
// and popped by an independent monitor; counters are checked against hand values.
module tb_dcache_profiler;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        valid_i;
    logic        we_i;
    logic [31:0] addr_i;
    logic        flush_i;
    logic        ready_o, hit_o, miss_o, wb_o;
    logic [31:0] access_cnt_o, hit_cnt_o, miss_cnt_o, wb_cnt_o, drop_cnt_o;
    logic [1:0]  dbg_state_o;

    int         vectors = 0;
    int         errs    = 0;
    logic [2:0] exp_q[$];
    logic [2:0] mon_exp;
    logic [2:0] mon_got;

    dcache_profiler #(.NUM_LINES(8), .LINE_BYTES(16)) dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .valid_i      (valid_i),
        .we_i         (we_i),
        .addr_i       (addr_i),
        .flush_i      (flush_i),
        .ready_o      (ready_o),
        .hit_o        (hit_o),
        .miss_o       (miss_o),
        .wb_o         (wb_o),
        .access_cnt_o (access_cnt_o),
        .hit_cnt_o    (hit_cnt_o),
        .miss_cnt_o   (miss_cnt_o),
        .wb_cnt_o     (wb_cnt_o),
        .drop_cnt_o   (drop_cnt_o),
        .dbg_state_o  (dbg_state_o)
    );

    // clock / reset
    always #5 clk_i = ~clk_i;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk_i);
        #1;
    endtask

    task automatic chk_cnt(input string name, input int acc, input int hit, input int miss,
                           input int wb, input int drop);
        chk({name, "_access"}, access_cnt_o, acc);
        chk({name, "_hit"},    hit_cnt_o,    hit);
        chk({name, "_miss"},   miss_cnt_o,   miss);
        chk({name, "_wb"},     wb_cnt_o,     wb);
        chk({name, "_drop"},   drop_cnt_o,   drop);
    endtask

    // exp = {hit, miss, wb}
    task automatic access(input logic we, input logic [31:0] addr, input logic flush,
                          input logic [2:0] exp);
        valid_i = 1'b1;
        we_i    = we;
        addr_i  = addr;
        flush_i = flush;
        exp_q.push_back(exp);
        cyc();
        valid_i = 1'b0;
        we_i    = 1'b0;
        flush_i = 1'b0;
    endtask

    // scoreboard monitor
    always @(negedge clk_i) begin
        if (hit_o || miss_o || wb_o) begin
            mon_got = {hit_o, miss_o, wb_o};
            if (exp_q.size() == 0) begin
                vectors++;
                errs++;
                $display("FAIL pulse_unexpected: got %b expected none", mon_got);
            end else begin
                mon_exp = exp_q.pop_front();
                chk("pulse", {29'b0, mon_got}, {29'b0, mon_exp});
            end
        end
    end

    initial begin
        rst_i   = 1'b0;
        valid_i = 1'b0;
        we_i    = 1'b0;
        addr_i  = '0;
        flush_i = 1'b0;
        cyc();
        cyc();
        chk("rst_ready", ready_o, 0);
        chk("rst_state", dbg_state_o, 0);
        chk_cnt("rst", 0, 0, 0, 0, 0);

        // INIT lasts 8 cycles; three accesses offered during it are dropped
        rst_i = 1'b1;
        for (int i = 0; i < 8; i++) begin
            chk("init_ready", ready_o, 0);
            valid_i = (i < 3);
            addr_i  = 32'h10;
            cyc();
        end
        valid_i = 1'b0;
        chk("init_done_ready", ready_o, 1);
        chk_cnt("init", 0, 0, 0, 0, 3);

        // read miss then back-to-back read hit on the same line
        access(1'b0, 32'h0000_0010, 1'b0, 3'b010);
        access(1'b0, 32'h0000_0010, 1'b0, 3'b100);
        chk_cnt("rd2", 2, 1, 1, 0, 3);

        // dirty victim eviction on index 2, then a clean eviction
        access(1'b1, 32'h0000_0020, 1'b0, 3'b010);
        access(1'b0, 32'h0000_0420, 1'b0, 3'b011);
        access(1'b0, 32'h0000_0020, 1'b0, 3'b010);
        chk_cnt("evict", 5, 1, 4, 1, 3);

        // dirty lines 0, 1, 3; last write shares its cycle with flush_i
        access(1'b1, 32'h0000_0000, 1'b0, 3'b010);
        access(1'b1, 32'h0000_0010, 1'b0, 3'b100);
        access(1'b1, 32'h0000_0030, 1'b1, 3'b010);
        chk("flush_state", dbg_state_o, 2);
        repeat (3) exp_q.push_back(3'b001);
        for (int i = 0; i < 8; i++) begin
            chk("flush_ready", ready_o, 0);
            flush_i = (i == 0);
            valid_i = (i == 4);
            addr_i  = 32'h0000_0050;
            cyc();
        end
        flush_i = 1'b0;
        valid_i = 1'b0;
        chk("flush_done_ready", ready_o, 1);
        cyc();
        chk("flush_not_requeued", ready_o, 1);
        chk_cnt("flush", 8, 2, 6, 4, 4);
        access(1'b0, 32'h0000_0000, 1'b0, 3'b010);
        chk_cnt("post_flush", 9, 2, 7, 4, 4);

        // reset in the middle of a flush, before dirty lines 5 and 7 are visited
        access(1'b1, 32'h0000_0050, 1'b0, 3'b010);
        access(1'b1, 32'h0000_0070, 1'b0, 3'b010);
        chk_cnt("pre_rst", 11, 2, 9, 4, 4);
        flush_i = 1'b1;
        cyc();
        flush_i = 1'b0;
        repeat (4) cyc();
        chk("midflush_state", dbg_state_o, 2);
        rst_i = 1'b0;
        cyc();
        chk("midrst_ready", ready_o, 0);
        chk("midrst_state", dbg_state_o, 0);
        chk("midrst_pulses", {29'b0, hit_o, miss_o, wb_o}, 0);
        chk_cnt("midrst", 0, 0, 0, 0, 0);
        rst_i = 1'b1;
        for (int i = 0; i < 8; i++) begin
            chk("reinit_ready", ready_o, 0);
            cyc();
        end
        chk("reinit_done_ready", ready_o, 1);
        access(1'b0, 32'h0000_0050, 1'b0, 3'b010);
        access(1'b0, 32'h0000_0070, 1'b0, 3'b010);
        chk_cnt("reinit", 2, 0, 2, 0, 0);

        repeat (3) cyc();
        chk("queue_empty", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end

endmodule

// File: doc/dcache_profiler.md
DCACHE_PROFILER -- requirements
Module: dcache_profiler

Interface
REQ-001 SHALL have parameter NUM_LINES, default 8, meaning the number of direct-mapped lines (power of 2, 2..256).
REQ-002 SHALL have parameter LINE_BYTES, default 16, meaning bytes per line (power of 2, 4..64).
REQ-003 SHALL have port clk_i  input  1  clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_i  input  1  reset; synchronous, active-low.
REQ-005 SHALL have port valid_i  input  1  data-memory access strobe (MemRead or MemWrite asserted).
REQ-006 SHALL have port we_i  input  1  1 = write access, 0 = read access; sampled only with valid_i.
REQ-007 SHALL have port addr_i  input  32  byte address of the access.
REQ-008 SHALL have port flush_i  input  1  request to write back and invalidate all lines.
REQ-009 SHALL have port ready_o  output  1  1 only in RUN state.
REQ-010 SHALL have ports hit_o, miss_o, wb_o  output  1 each  single-cycle result pulses.
REQ-011 SHALL have ports access_cnt_o, hit_cnt_o, miss_cnt_o, wb_cnt_o, drop_cnt_o  output  32 each  statistics counters.

Function
REQ-012 SHALL decode OFF=log2(LINE_BYTES) and IDX=log2(NUM_LINES): index = addr_i[OFF+IDX-1:OFF], tag = addr_i[31:OFF+IDX].
REQ-013 SHALL hold per line: valid bit, dirty bit, and a tag register.
REQ-014 SHALL implement the states INIT, RUN and FLUSH.
REQ-015 INIT SHALL clear one line per cycle, index 0..NUM_LINES-1, then go to RUN; it lasts exactly NUM_LINES cycles.
REQ-016 An access is accepted when valid_i=1 and ready_o=1.
REQ-017 On an accepted access, hit = line valid and tag equal; otherwise it is a miss.
REQ-018 Read hit SHALL leave the line unchanged; write hit SHALL set dirty.
REQ-019 Miss SHALL allocate: tag written, valid=1, dirty=we_i.
REQ-020 If the victim line is valid and dirty, the miss SHALL also count as a write-back.
REQ-021 hit_o/miss_o/wb_o SHALL be registered and pulse for exactly one cycle, the cycle after acceptance; latency 1.
REQ-022 Back-to-back accepted accesses to the same index SHALL observe the previous access's update, with no stall.
REQ-023 access_cnt_o SHALL increment per accepted access; hit_cnt_o, miss_cnt_o and wb_cnt_o SHALL increment with their respective pulses.
REQ-024 valid_i=1 while ready_o=0 SHALL increment drop_cnt_o only; no cache state or other counter changes.
REQ-025 All counters SHALL saturate at 0xFFFFFFFF and never wrap.
REQ-026 flush_i=1 in RUN SHALL enter FLUSH next cycle.
REQ-027 An access accepted in the same cycle as flush_i SHALL be processed normally before the flush.
REQ-028 FLUSH SHALL visit one line per cycle, index 0..NUM_LINES-1: each valid+dirty line increments wb_cnt_o and pulses wb_o the following cycle; every line is invalidated and cleaned; then return to RUN.
REQ-029 flush_i in INIT or FLUSH SHALL be ignored and SHALL NOT be queued.
REQ-030 When a FLUSH write-back and an access write-back coincide, wb_cnt_o SHALL increment by the number of events.

Reset
REQ-031 rst_i=0 at a rising edge SHALL force: state INIT, index walker 0, ready_o=0, hit_o=miss_o=wb_o=0, all counters 0.
REQ-032 Reset SHALL take priority over all inputs, including mid-FLUSH or mid-INIT.
REQ-033 After rst_i returns to 1, ready_o SHALL rise exactly NUM_LINES cycles later.

Verification (NUM_LINES=8, LINE_BYTES=16)
REQ-034 Reset release -> ready_o=0 for 8 cycles, then 1; all five counters read 0.
REQ-035 Read 0x00000010 twice, back-to-back -> miss_o, then hit_o on the next cycle; access_cnt=2, hit_cnt=1, miss_cnt=1, wb_cnt=0.
REQ-036 Write 0x00000020, then read 0x00000420 (same index 2, tag 0x8) -> both miss; second miss has wb_o=1; wb_cnt=1; then read 0x00000020 -> miss, no wb.
REQ-037 Write 0x00, 0x10, 0x30, then flush_i -> ready_o=0 for 8 cycles, wb_cnt=+3, three wb_o pulses; then read 0x00 -> miss.
REQ-038 valid_i=1 for 3 cycles during INIT -> drop_cnt=3; access_cnt, hit_cnt, miss_cnt, wb_cnt unchanged.
REQ-039 rst_i=0 at flush cycle 4 -> counters 0, INIT restarts, full 8-cycle INIT before ready_o=1; the previously dirty lines are gone (read miss, no wb).
